// File: rtl/xclk_arb_pkg.sv
// Shared types for the cross-clock request arbiter.
// StDrain only exists when XCLK_ARB_TIMEOUT_EN is defined.
package xclk_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StArm,
        StWait,
        StAck
`ifdef XCLK_ARB_TIMEOUT_EN
        ,
        StDrain
`endif
    } xarb_state_t;

    // The round-robin pointer resets to N-1 so that requester 0 wins first.
    function automatic int unsigned XARB_LAST_RST(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req at or after last+1 (mod N) wins.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] last_i,
    output logic [IdW-1:0] win_id_o,
    output logic           any_o
);

    always_comb begin
        win_id_o = last_i;
        any_o    = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (int'(last_i) + k) % int'(N);
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                win_id_o = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/xclk_req_arbiter.sv
// Round-robin arbiter sharing one acknowledged toggle-flag CDC channel among N requesters.
// Optional busy timeout with abort and drain: define XCLK_ARB_TIMEOUT_EN.
module xclk_req_arbiter
    import xclk_arb_pkg::*;
#(
    parameter int unsigned N              = 4,
    parameter int unsigned W              = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    input  logic [N*W-1:0]       req_data_i,
    output logic [N-1:0]         ack_o,
    output logic [$clog2(N)-1:0] grant_id_o,
    output logic                 active_o,
    output logic                 ch_sig_o,
    output logic [W-1:0]         ch_data_o,
    input  logic                 ch_busy_i,
    output logic                 to_err_o
);

    localparam int unsigned IdW = $clog2(N);
    localparam logic [IdW-1:0] LastRst = IdW'(XARB_LAST_RST(N));

    if (N < 2 || N > 16 || W == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("xclk_req_arbiter: parameter out of range");
    end

    xarb_state_t    state_q, state_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic [IdW-1:0] last_q, last_d;
    logic [W-1:0]   ch_data_q, ch_data_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           active_q, active_d;
    logic           ch_sig_q, ch_sig_d;

    logic [IdW-1:0] win_id;
    logic           win_any;

`ifdef XCLK_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_err_q, to_err_d;
`endif

    rr_pick #(
        .N   (N),
        .IdW (IdW)
    ) u_rr_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .win_id_o (win_id),
        .any_o    (win_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        ch_data_d  = ch_data_q;
        active_d   = active_q;
        ack_d      = '0;
        ch_sig_d   = 1'b0;
`ifdef XCLK_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        to_err_d   = 1'b0;
`endif
        // Outputs are registered, so each one is set on the edge entering its state.
        unique case (state_q)
            StIdle: begin
                if (!ch_busy_i && win_any) begin
                    state_d    = StIssue;
                    grant_id_d = win_id;
                    ch_data_d  = req_data_i[int'(win_id) * int'(W) +: W];
                    active_d   = 1'b1;
                    ch_sig_d   = 1'b1;
                end
            end
            StIssue: begin
                state_d = StArm;
`ifdef XCLK_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StArm: begin
                state_d = StWait;
`ifdef XCLK_ARB_TIMEOUT_EN
                cnt_d   = cnt_q + 1'b1;
`endif
            end
            StWait: begin
`ifdef XCLK_ARB_TIMEOUT_EN
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (!ch_busy_i) begin
                    state_d            = StAck;
                    ack_d[grant_id_q]  = 1'b1;
`ifdef XCLK_ARB_TIMEOUT_EN
                end else if (cnt_q == CntMax) begin
                    state_d            = StAck;
                    ack_d[grant_id_q]  = 1'b1;
                    to_err_d           = 1'b1;
`endif
                end
            end
            StAck: begin
                last_d   = grant_id_q;
                active_d = 1'b0;
`ifdef XCLK_ARB_TIMEOUT_EN
                state_d  = to_err_q ? StDrain : StIdle;
`else
                state_d  = StIdle;
`endif
            end
`ifdef XCLK_ARB_TIMEOUT_EN
            StDrain: begin
                if (!ch_busy_i) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            last_q     <= LastRst;
            ch_data_q  <= '0;
            active_q   <= 1'b0;
            ack_q      <= '0;
            ch_sig_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            ch_data_q  <= ch_data_d;
            active_q   <= active_d;
            ack_q      <= ack_d;
            ch_sig_q   <= ch_sig_d;
        end
    end

`ifdef XCLK_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign to_err_o = to_err_q;
`else
    assign to_err_o = 1'b0;
`endif

    assign ack_o      = ack_q;
    assign grant_id_o = grant_id_q;
    assign active_o   = active_q;
    assign ch_sig_o   = ch_sig_q;
    assign ch_data_o  = ch_data_q;

endmodule

// File: tb/tb_xclk_req_arbiter.sv
// Directed + randomized bench for xclk_req_arbiter against a transaction-timeline model.
// Timeout scenario runs only when XCLK_ARB_TIMEOUT_EN is defined.
module tb_xclk_req_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned TO  = 8;
    localparam int unsigned IdW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           ch_busy = 1'b0;
    logic [N-1:0]   ack;
    logic [IdW-1:0] grant_id;
    logic           active;
    logic           ch_sig;
    logic [W-1:0]   ch_data;
    logic           to_err;

    always #5 clk = ~clk;

    xclk_req_arbiter #(
        .N              (N),
        .W              (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .req_data_i (req_data),
        .ack_o      (ack),
        .grant_id_o (grant_id),
        .active_o   (active),
        .ch_sig_o   (ch_sig),
        .ch_data_o  (ch_data),
        .ch_busy_i  (ch_busy),
        .to_err_o   (to_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Channel stimulus: busy for 'hold' cycles after each grant, plus forced/noise busy.
    bit           force_busy = 0;
    bit           noise_busy = 0;
    int           chan_cnt = 0;
    int           hold = 3;
    logic [N-1:0] pend_drop = '0;

    // Reference model: timeline of one transaction measured in edges since the grant.
    bit             m_inflight, m_ackph, m_drain, m_terr_pend;
    int             m_age;
    logic [IdW-1:0] m_last, m_gid;
    logic [W-1:0]   m_data;
    logic [N-1:0]   m_ack;
    logic           m_active, m_sig, m_terr;

    // Observations for directed scenario checks.
    int unsigned sig_q[$];
    int          sig_cyc[$];
    int          ack_cnt[N];
    int          terr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inflight  = 0;
        m_ackph     = 0;
        m_drain     = 0;
        m_terr_pend = 0;
        m_age       = 0;
        m_last      = IdW'(N - 1);
        m_gid       = '0;
        m_data      = '0;
        m_ack       = '0;
        m_active    = 0;
        m_sig       = 0;
        m_terr      = 0;
        chan_cnt    = 0;
        pend_drop   = '0;
    endtask

    function automatic int rr_next(input logic [N-1:0] r, input logic [IdW-1:0] last);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (int'(last) + k) % int'(N);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Apply the arbitration rules to the inputs sampled at this edge.
    task automatic model_edge();
        m_sig  = 0;
        m_ack  = '0;
        m_terr = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_drain) begin
            if (!ch_busy) m_drain = 0;
        end else if (!m_inflight) begin
            if (!ch_busy && req != '0) begin
                int g;
                g          = rr_next(req, m_last);
                m_gid      = IdW'(g);
                m_data     = req_data[g * int'(W) +: W];
                m_inflight = 1;
                m_age      = 0;
                m_sig      = 1;
                m_active   = 1;
            end
        end else if (m_ackph) begin
            m_ackph     = 0;
            m_inflight  = 0;
            m_active    = 0;
            m_last      = m_gid;
            m_drain     = m_terr_pend;
            m_terr_pend = 0;
        end else begin
            m_age++;
            if (m_age >= 3 && !ch_busy) begin
                m_ack[m_gid] = 1'b1;
                m_ackph      = 1;
`ifdef XCLK_ARB_TIMEOUT_EN
            end else if (m_age >= 3 && (m_age - 2) >= int'(TO)) begin
                m_ack[m_gid] = 1'b1;
                m_terr       = 1;
                m_ackph      = 1;
                m_terr_pend  = 1;
`endif
            end
        end
    endtask

    task automatic step();
        ch_busy = force_busy | (chan_cnt != 0) | noise_busy;
        @(posedge clk);
        model_edge();
        if (chan_cnt != 0) chan_cnt--;
        if (m_sig) chan_cnt = hold;
        #1;
        cyc++;
        chk("ack", 32'(ack), 32'(m_ack));
        chk("ch_sig", 32'(ch_sig), 32'(m_sig));
        chk("active", 32'(active), 32'(m_active));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("ch_data", 32'(ch_data), 32'(m_data));
        chk("to_err", 32'(to_err), 32'(m_terr));
        if (ch_sig === 1'b1) begin
            sig_q.push_back(32'(grant_id));
            sig_cyc.push_back(cyc);
        end
        for (int i = 0; i < int'(N); i++) if (ack[i] === 1'b1) ack_cnt[i]++;
        if (to_err === 1'b1) terr_cnt++;
        // Requesters drop req at the edge that ends their ack cycle.
        req       = req & ~pend_drop;
        pend_drop = m_ack;
    endtask

    task automatic clear_obs();
        sig_q.delete();
        sig_cyc.delete();
        for (int i = 0; i < int'(N); i++) ack_cnt[i] = 0;
        terr_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_obs();

        // Reset values.
        do_reset();

        // Single request from requester 1, 3-cycle busy window.
        hold = 3;
        req_data[1*W +: W] = 16'hBEEF;
        req = 4'b0010;
        repeat (12) step();
        chk("single_ack_cnt", 32'(ack_cnt[1]), 32'd1);
        chk("single_sig_cnt", 32'(sig_q.size()), 32'd1);

        // All four from reset: order 0,1,2,3 and pulse spacing.
        do_reset();
        clear_obs();
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        repeat (30) step();
        chk("rr_grants", 32'(sig_q.size()), 32'd4);
        for (int i = 0; i < sig_q.size() && i < 4; i++) chk("rr_order", sig_q[i], 32'(i));
        for (int i = 1; i < sig_cyc.size(); i++)
            chk("rr_gap_ge5", 32'((sig_cyc[i] - sig_cyc[i-1]) >= 5), 32'd1);
        for (int i = 0; i < int'(N); i++) chk("rr_ack_once", 32'(ack_cnt[i]), 32'd1);

        // Busy held through reset release.
        force_busy = 1;
        do_reset();
        clear_obs();
        req = 4'b0001;
        repeat (6) step();
        chk("busy_no_sig", 32'(sig_q.size()), 32'd0);
        force_busy = 0;
        repeat (8) step();
        chk("busy_then_ack", 32'(ack_cnt[0]), 32'd1);

        // Payload changes right after grant are ignored.
        req_data[2*W +: W] = 16'h1234;
        req = 4'b0100;
        step();
        req_data[2*W +: W] = 16'h5678;
        repeat (2) step();
        chk("data_hold", 32'(ch_data), 32'h1234);
        repeat (8) step();

        // Reset asserted in WAIT drops the transaction.
        clear_obs();
        hold = 100;
        req = 4'b0001;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_sig", 32'(ch_sig), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_gid", 32'(grant_id), 32'd0);
        chk("arst_data", 32'(ch_data), 32'd0);
        req = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        hold = 3;
        repeat (8) step();
        chk("arst_no_ack", 32'(ack_cnt[0]), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < int'(N); i++)
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            req_data   = {$urandom, $urandom};
            hold       = int'($urandom_range(0, 6));
            noise_busy = ($urandom_range(0, 9) == 0);
            step();
        end
        noise_busy = 0;
        req = '0;
        repeat (15) step();

`ifdef XCLK_ARB_TIMEOUT_EN
        // Stuck busy: abort with to_err, then no grant until busy clears.
        clear_obs();
        force_busy = 1;
        req = 4'b0011;
        repeat (25) step();
        chk("to_err_cnt", 32'(terr_cnt), 32'd1);
        chk("to_grants", 32'(sig_q.size()), 32'd1);
        force_busy = 0;
        hold = 3;
        repeat (12) step();
        chk("to_recover", 32'(ack_cnt[1]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xclk_req_arbiter.md
# xclk_req_arbiter

Round-robin arbiter that shares one acknowledged clock-domain-crossing channel (toggle-flag request, `busy` returned through a 2-FF synchronizer) among N requesters in the write-clock domain. It latches the winning requester's payload, holds it stable for the entire crossing, and issues exactly one single-cycle request pulse. It then waits for the channel's `busy` to clear and returns a one-cycle `ack` to the winner. It sits in front of the channel, e.g. multiplexing command words from several host-side units onto one link into the core-clock domain.

## Interface
- `N`, 4: number of requesters, 2..16.
- `W`, 16: payload width per requester.
- `TIMEOUT_CYCLES`, 1024: wait limit in cycles; used only with the timeout feature.
- `clk` in 1: write-side clock; all logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N: per-requester request level; held high until its `ack`.
- `req_data` in N*W: payloads; requester i owns bits [i*W +: W].
- `ack` out N: one-hot, one-cycle completion pulse.
- `grant_id` out $clog2(N): index of the current or last winner.
- `active` out 1: high from grant until the ACK cycle, inclusive.
- `ch_sig` out 1: request pulse into the channel.
- `ch_data` out W: latched payload, stable from ISSUE through ACK.
- `ch_busy` in 1: channel busy; high while the crossing is outstanding.
- `to_err` out 1: with timeout feature only; one-cycle pulse, coincident with the aborted grant's `ack`.

## Operation
- States: IDLE, ISSUE, ARM, WAIT, ACK (plus DRAIN with the timeout feature).
- **IDLE**
  - If `ch_busy`=0 and any `req` is high, pick a winner round-robin, starting at `last+1` mod N.
  - Register the winner into `grant_id` and its payload into `ch_data`, then go to ISSUE.
  - If `ch_busy`=1, stay in IDLE and grant nothing.
- **ISSUE**: `ch_sig`=1 for exactly this cycle, then go to ARM.
- **ARM**: one cycle; `ch_busy` is ignored here because it is still low until the toggle propagates. Go to WAIT.
- **WAIT**: stay while `ch_busy`=1. On the first cycle `ch_busy`=0, go to ACK.
- **ACK**
  - `ack[grant_id]`=1 for this cycle only.
  - Update `last`=`grant_id`, then go to IDLE.
- Requesters drop `req` at the clock edge that ends their `ack` cycle. A `req` still high in a later IDLE cycle counts as a new request.
- `req` low during ISSUE, ARM or WAIT does not cancel the transaction; the crossing completes and `ack` still fires.
- `req_data` is sampled only at grant. Changes after grant are ignored.
- All registered outputs are reset values:
  - `ack`=0, `ch_sig`=0, `ch_data`=0, `grant_id`=0, `active`=0, `to_err`=0.
  - state = IDLE; `last`=N-1, so requester 0 wins first.
- Reset mid-transaction drops the transaction with no `ack`. After reset, IDLE waits for `ch_busy`=0 before the next grant.

## Timing
- All outputs are registered.
- `req[i]` high at edge t, in IDLE with `ch_busy`=0:
  - `grant_id`, `ch_data` and `active` are valid from t+1.
  - `ch_sig` is high during cycle t+1 only.
- `ack` is asserted 1 cycle after the first sampled `ch_busy`=0 in WAIT.
- Minimum `req`-to-`ack` is 4 cycles, reached when `ch_busy` is already 0 in the first WAIT cycle.
- Back-to-back grants: a second pending request is granted in the IDLE cycle right after ACK. So `ch_sig` pulses are at least 5 cycles apart.
- Simultaneous requests: exactly one grant per IDLE cycle. The rotation guarantees each active requester is served within N transactions.

## Configuration
- `XCLK_ARB_TIMEOUT_EN` defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears in ISSUE and increments in ARM and WAIT.
  - On reaching `TIMEOUT_CYCLES` while `ch_busy`=1, go to ACK with `to_err`=1 (the winner still gets `ack`), then to DRAIN.
  - DRAIN waits for `ch_busy`=0 without granting, then goes to IDLE.
- Not defined: no counter, no DRAIN state. `to_err` is tied to 0, and WAIT is unbounded.

## Structure
- Package `xclk_arb_pkg`: state enum `xarb_state_t` and the reset constant `XARB_LAST_RST`. Widths are derived from `N` and `TIMEOUT_CYCLES` with `$clog2`.
- Sub-module `rr_pick`:
  - Combinational round-robin priority picker: inputs are `req`[N] and `last`; outputs are `win_id` and `any`.
  - Instantiated once in IDLE-decode logic.

## Test plan
- Single request: `req`=4'b0010, `req_data[1]`=16'hBEEF, `ch_busy` driven from a channel model with 3 cycles of latency.
  - Expect `ch_sig` for one cycle, `ch_data`=16'hBEEF until ACK, and `ack`=4'b0010 exactly once.
- All four requesting from reset: grant order 0,1,2,3, each `ack` exactly once, `ch_sig` pulses at least 5 cycles apart.
- `ch_busy` held at 1 through reset release with `req`=4'b0001: no `ch_sig` until `ch_busy` falls, then a normal transaction.
- `req_data[2]` changes right after grant: `ch_data` keeps the value sampled at grant.
- Reset asserted in WAIT: outputs return to reset values immediately, and no `ack` is produced for the aborted transaction.
- `XCLK_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8 and `ch_busy` stuck at 1:
  - Expect `ack` together with `to_err` for one cycle, then no new grant until `ch_busy`=0.
